// File: rtl/flow_led_ctrl_if.sv
// flow_led_ctrl_if
// Groups the control inputs and status outputs of the flowing-LED sequencer.
// The sequencer sits on the slave side. A board wrapper or a bench sits on the master side.
//   start     : begin a sequence from idle (level-sampled)
//   stop      : return to idle from any state (level-sampled)
//   pause     : freeze the sequence while high
//   dir_sel   : pattern select (00 left, 01 right, 10 bounce, 11 left)
//   led_out   : one-hot lit LED, or all zero
//   step_done : one-cycle pulse in the first cycle of each new position
//   busy      : high whenever the sequencer is not idle
interface flow_led_ctrl_if #(
  parameter int LED_NUM = 4
);
  logic               start;
  logic               stop;
  logic               pause;
  logic [1:0]         dir_sel;
  logic [LED_NUM-1:0] led_out;
  logic               step_done;
  logic               busy;

  modport master (
    output start, stop, pause, dir_sel,
    input  led_out, step_done, busy
  );

  modport slave (
    input  start, stop, pause, dir_sel,
    output led_out, step_done, busy
  );
endinterface

// File: rtl/flow_led_ctrl.sv
// flow_led_ctrl
// Steps a single lit position across LED_NUM LEDs. Each position is held for T_STEP
// cycles and is lit only for the first T_ON of them. One shared step counter drives
// every LED, so all LEDs stay phase-locked.
// Ports:
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset
//   bus : flow_led_ctrl_if slave (start/stop/pause/dir_sel in; led_out/step_done/busy out)
module flow_led_ctrl #(
  parameter int LED_NUM = 4,
  parameter int CNT_W   = 25,
  parameter int T_STEP  = 25_000_000,
  parameter int T_ON    = 6_250_000
) (
  input logic            clk,
  input logic            rst,
  flow_led_ctrl_if.slave bus
);

  localparam int POS_W = (LED_NUM > 2) ? $clog2(LED_NUM) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [1:0] DIR_RIGHT  = 2'b01;
  localparam logic [1:0] DIR_BOUNCE = 2'b10;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(LED_NUM - 1);
  localparam logic [POS_W-1:0] PEN_POS  = POS_W'(LED_NUM - 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(T_STEP - 1);
  localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(T_ON);
  // When T_ON equals T_STEP, T_ON itself may not fit in CNT_W bits, so the
  // "always lit" case is handled separately rather than through the compare.
  localparam bit ALWAYS_ON = (T_ON >= T_STEP);

  logic [1:0]         state;
  logic [CNT_W-1:0]   count;
  logic [POS_W-1:0]   pos;
  logic [1:0]         dir_lat;
  logic               bounce_up;
  logic               step_done;
  logic [POS_W-1:0]   next_pos;
  logic               next_bounce_up;
  logic [LED_NUM-1:0] led_vec;

  // Work out where the lit position moves on a step wrap.
  // The pattern comes from the direction latched at start, so later dir_sel
  // changes cannot disturb a running sequence. Bounce turns around at the
  // end LEDs, and bounce_up records which way it is currently heading.
  always_comb begin
    next_pos       = pos;
    next_bounce_up = bounce_up;
    case (dir_lat)
      DIR_RIGHT: next_pos = (pos == '0) ? LAST_POS : pos - POS_W'(1);
      DIR_BOUNCE: begin
        if (bounce_up) begin
          next_pos = pos + POS_W'(1);
          if (pos == PEN_POS) next_bounce_up = 1'b0;
        end else begin
          next_pos = pos - POS_W'(1);
          if (pos == POS_W'(1)) next_bounce_up = 1'b1;
        end
      end
      default: next_pos = (pos == LAST_POS) ? '0 : pos + POS_W'(1);
    endcase
  end

  // Main sequencer state.
  // Stop beats pause, and pause beats start. The edge that releases a pause
  // counts like an ordinary RUN edge (it may even wrap and advance). This means
  // each paused cycle stretches the step by exactly one cycle, and the lit time
  // outside the pause stays at T_ON. step_done is raised only on a real RUN wrap,
  // so a stop or pause on the wrap edge swallows the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      pos       <= '0;
      dir_lat   <= 2'b00;
      bounce_up <= 1'b1;
      step_done <= 1'b0;
    end else begin
      step_done <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (bus.start && !bus.stop) begin
            dir_lat   <= bus.dir_sel;
            bounce_up <= 1'b1;
            pos       <= (bus.dir_sel == DIR_RIGHT) ? LAST_POS : '0;
            state     <= bus.pause ? HOLD : RUN;
          end
        end
        RUN, HOLD: begin
          if (bus.stop) begin
            state <= IDLE;
            count <= '0;
          end else if (bus.pause) begin
            state <= HOLD;
          end else begin
            state <= RUN;
            if (count == CNT_LAST) begin
              count     <= '0;
              pos       <= next_pos;
              bounce_up <= next_bounce_up;
              step_done <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Output decode, which uses registered state only.
  // The LED is lit during the early part of each step and stays dark for the
  // rest of the step. While paused, the LED shows whatever the frozen count
  // implies.
  always_comb begin
    led_vec = '0;
    if (state != IDLE && (ALWAYS_ON || count < CNT_ON)) led_vec[pos] = 1'b1;
  end

  assign bus.led_out   = led_vec;
  assign bus.busy      = (state != IDLE);
  assign bus.step_done = step_done;

endmodule

// File: tb/tb_flow_led_ctrl.sv
// tb_flow_led_ctrl
// Directed bench for flow_led_ctrl with LED_NUM=4, T_STEP=8, T_ON=2.
// Inputs change 1 ns after each rising edge. Outputs are sampled at that same
// point, so each check sees the state produced by the edge just taken.
module tb_flow_led_ctrl;
  localparam int LED_NUM = 4;
  localparam int T_STEP  = 8;
  localparam int T_ON    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_seq[8];

  flow_led_ctrl_if #(.LED_NUM(LED_NUM)) bus();

  flow_led_ctrl #(
    .LED_NUM(LED_NUM),
    .CNT_W  (3),
    .T_STEP (T_STEP),
    .T_ON   (T_ON)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [31:0] onehot(input int p);
    return 32'(1) << p;
  endfunction

  // Drive one set of inputs and take one rising edge.
  task automatic applyStimulus(input logic s_start, input logic s_stop,
                               input logic s_pause, input logic [1:0] s_dir);
    bus.start   = s_start;
    bus.stop    = s_stop;
    bus.pause   = s_pause;
    bus.dir_sel = s_dir;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    if (obs !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag, input logic [31:0] led, input logic sd, input logic bsy);
    checkOutput({tag, " led"},  32'(bus.led_out),   led);
    checkOutput({tag, " done"}, 32'(bus.step_done), 32'(sd));
    checkOutput({tag, " busy"}, 32'(bus.busy),      32'(bsy));
  endtask

  // Run the pattern described by exp_seq for nsteps positions, stopping on a wrap edge.
  // Part way through, dir_sel is changed and start is pulsed. Neither may have any effect.
  task automatic runPattern(input logic [1:0] dir, input int nsteps);
    logic [1:0] d;
    logic [1:0] other;
    logic [31:0] led;
    d = dir;
    other = (dir == 2'b01) ? 2'b10 : 2'b01;
    applyStimulus(1'b1, 1'b0, 1'b0, d);
    for (int k = 0; k < nsteps * T_STEP - 1; k++) begin
      led = ((k % T_STEP) < T_ON) ? onehot(exp_seq[k / T_STEP]) : 32'd0;
      checkAll($sformatf("dir%0d e%0d", dir, k), led, (k % T_STEP == 0) && (k > 0), 1'b1);
      if (k == 12) d = other;
      applyStimulus(k == 20, 1'b0, 1'b0, d);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, d);
    checkAll($sformatf("dir%0d stop at wrap", dir), 32'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, d);
    checkAll($sformatf("dir%0d idle", dir), 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.dir_sel = 2'b00;

    // Reset held for three cycles, then idle with start low.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
      checkAll($sformatf("reset %0d", i), 32'd0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
      checkAll($sformatf("idle %0d", i), 32'd0, 1'b0, 1'b0);
    end

    // Left, right and bounce patterns.
    exp_seq = '{0, 1, 2, 3, 0, 0, 0, 0};
    runPattern(2'b00, 5);
    exp_seq = '{3, 2, 1, 0, 3, 0, 0, 0};
    runPattern(2'b01, 5);
    exp_seq = '{0, 1, 2, 3, 2, 1, 0, 1};
    runPattern(2'b10, 8);

    // Pause for five cycles at count 1. The step stretches to 13 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkAll("pause e0", 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("pause e1", 32'h1, 1'b0, 1'b1);
    for (int e = 2; e <= 6; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
      checkAll($sformatf("pause held e%0d", e), 32'h1, 1'b0, 1'b1);
    end
    for (int e = 7; e <= 12; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
      checkAll($sformatf("pause dark e%0d", e), 32'h0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("pause advance e13", 32'h2, 1'b1, 1'b1);
    for (int e = 14; e <= 20; e++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("pre-wrap e20", 32'h0, 1'b0, 1'b1);

    // A pause on the wrap edge delays both the advance and step_done.
    for (int e = 21; e <= 22; e++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
      checkAll($sformatf("wrap pause e%0d", e), 32'h0, 1'b0, 1'b1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("wrap release e23", 32'h4, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("after release e24", 32'h4, 1'b0, 1'b1);

    // Stop and pause together in RUN go to IDLE.
    applyStimulus(1'b0, 1'b1, 1'b1, 2'b00);
    checkAll("stop+pause", 32'h0, 1'b0, 1'b0);

    // Start with pause held goes straight to HOLD at position 0.
    applyStimulus(1'b1, 1'b0, 1'b1, 2'b00);
    checkAll("start into hold", 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 2'b00);
    checkAll("hold frozen", 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("hold release", 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("hold then dark", 32'h0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    checkAll("stop from run", 32'h0, 1'b0, 1'b0);

    // Stop and start together in IDLE stay idle.
    applyStimulus(1'b1, 1'b1, 1'b0, 2'b00);
    checkAll("stop+start idle", 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("still idle", 32'h0, 1'b0, 1'b0);

    // Reset mid-run at pos 2, count 5, then restart from position 0.
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    for (int e = 1; e <= 16; e++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("midrun e16", 32'h4, 1'b1, 1'b1);
    for (int e = 17; e <= 21; e++) applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("midrun e21", 32'h0, 1'b0, 1'b1);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'b00);
    checkAll("reset midrun", 32'h0, 1'b0, 1'b0);
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 2'b00);
    checkAll("restart", 32'h1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 2'b00);
    checkAll("final stop", 32'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/flow_led_ctrl.md
# flow_led_ctrl

Sequencer for the flowing-LED board demo. Steps a single lit position across `LED_NUM` LEDs, holding each position for `T_STEP` clock cycles and lighting it only for the first `T_ON` cycles of that step. Supports left, right and bounce patterns plus start, stop and pause control. It replaces per-LED free-running timers with one shared step counter, so all LEDs stay phase-locked.

## Interface

**Parameters**
- `LED_NUM`, default 4: number of LEDs, ≥2.
- `CNT_W`, default 25: step counter width; must hold `T_STEP-1`.
- `T_STEP`, default 25_000_000: cycles per step (500 ms at 50 MHz), ≥2.
- `T_ON`, default 6_250_000: lit cycles at the start of each step; 1 ≤ `T_ON` ≤ `T_STEP`.

**Ports**
- `CLK` in 1: single clock; all logic on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `Start` in 1: level-sampled; begins a sequence from IDLE.
- `Stop` in 1: level-sampled; returns to IDLE from any state.
- `Pause` in 1: level; freezes the sequence while high.
- `Dir_Sel` in 2: pattern select. 00 = left, 01 = right, 10 = bounce, 11 = treated as left.
- `LED_Out` out `LED_NUM`: one-hot lit LED, or all zero.
- `Step_Done` out 1: one-cycle pulse on each position advance.
- `Busy` out 1: high when the state is not IDLE.

## Operation

- State machine has three states: IDLE, RUN and HOLD. Registered state consists of `State`, `Count[CNT_W-1:0]`, `Pos` (index), `Dir_Lat[1:0]`, `Bounce_Up` and `Step_Done`.
- Input priority at each edge is `Stop` > `Pause` > `Start`.
- **IDLE**
  - `Count`=0 and `LED_Out`=0.
  - On `Start`=1 (and `Stop`=0): latch `Dir_Sel` into `Dir_Lat`, set `Count`=0, `Bounce_Up`=1, and go to RUN.
  - Start position is `Pos`=`LED_NUM-1` for right, otherwise 0.
  - If `Pause` is high on the same edge, go straight to HOLD with the same initialisation.
- **RUN**
  - Each edge: if `Count`==`T_STEP-1`, set `Count`=0, advance `Pos`, and set `Step_Done`=1 for the next cycle. Otherwise increment `Count`.
  - `Pause`=1 → HOLD with no update to `Count` or `Pos`, including on the wrap edge (no advance, no `Step_Done`).
  - `Stop`=1 → IDLE.
  - `Start` is ignored.
- **HOLD**
  - `Count`, `Pos` and `Bounce_Up` are frozen, and `LED_Out` holds its decoded value.
  - `Pause`=0 → RUN; counting resumes from the frozen `Count` on the following edge.
  - `Stop`=1 → IDLE.
- **Advance rules**
  - Left: `Pos`+1, wrapping from `LED_NUM-1` to 0.
  - Right: `Pos`−1, wrapping from 0 to `LED_NUM-1`.
  - Bounce: move up while `Bounce_Up`. At `Pos`=`LED_NUM-2` moving up, go to `LED_NUM-1` and clear `Bounce_Up`. Mirror this going down (`Pos`=1 → 0, set `Bounce_Up`). For 4 LEDs the sequence is 0,1,2,3,2,1,0,1…
- `Dir_Sel` changes are ignored until the next IDLE→RUN transition.
- **Output decode** (from registered state only, with no combinational path from inputs):
  - `LED_Out` = onehot(`Pos`) when `State`≠IDLE and `Count`<`T_ON`, else 0.
  - `Busy` = (`State`≠IDLE).
- `Step_Done` is a register; it is cleared on any edge that is not a RUN wrap.
- **Reset**, whenever `RST`=1 at an edge, mid-sequence included:
  - `State`=IDLE, `Count`=0, `Pos`=0, `Dir_Lat`=00, `Bounce_Up`=1.
  - `LED_Out`=0, `Step_Done`=0, `Busy`=0.

## Timing

- Latency from the `Start` edge: `LED_Out` shows the start position in the very next cycle. `Busy` rises at the same time.
- Each position is held for exactly `T_STEP` cycles: lit for `T_ON`, then dark for `T_STEP-T_ON`. With `T_ON`=`T_STEP` the LED is lit continuously.
- `Step_Done` is high during the first cycle of the new step, when `Count`=0 and the new `Pos` is shown.
- HOLD adds exactly one cycle per paused cycle. The total lit time per step is preserved across a pause.
- `Stop` clears `LED_Out` and `Busy` in the cycle after the edge. A `Step_Done` scheduled on that edge is suppressed.
- Counter arithmetic is unsigned, modulo `T_STEP`. `Count` never reaches `T_STEP`.

## Test plan

All scenarios use `LED_NUM`=4, `T_STEP`=8, `T_ON`=2.

- **Reset:** hold `RST` for 3 cycles, then release → `LED_Out`=0000, `Busy`=0 and `Step_Done`=0 throughout. `Start` low keeps IDLE.
- **Left run:** `Dir_Sel`=00 with a 1-cycle `Start` → `LED_Out` = 0001 for 2 cycles then 0000 for 6; then 0010, 0100, 1000, 0001 at 8-cycle intervals. `Step_Done` pulses at cycles 8, 16, 24 and 32 after `Start`.
- **Right and bounce:** with `Dir_Sel`=01, positions run 3,2,1,0,3. With `Dir_Sel`=10, positions run 0,1,2,3,2,1,0,1. Changing `Dir_Sel` mid-run has no effect.
- **Pause:** assert `Pause` for 5 cycles at `Count`=1 → `LED_Out` holds its lit value. The step lasts 13 cycles in total and the LED is lit for 2 non-paused cycles. A pause asserted on the wrap edge delays the advance and `Step_Done`.
- **Stop/Start collisions:** `Stop`+`Start` together in IDLE stays IDLE. `Stop`+`Pause` in RUN goes to IDLE. `Start` during RUN is ignored (no position reset).
- **Reset mid-run:** `RST` at `Pos`=2, `Count`=5 → next cycle all outputs are 0. A following `Start` restarts at position 0.
